data_ram_ctrl: RTL and testbench

- Parametrised successor to the 256x16 data RAM in the memory subsystem.
- Simple dual-port memory: one write port, one read port.
- Adds per-byte write enables, registered reads with a valid strobe, and write-first forwarding on same-address collisions.
- Adds out-of-range detection and a hardware clear engine that zeroes the whole array after reset or on request.
- Sits between the CPU datapath (MDR/MAR) and storage.

---
 rtl/data_ram_pkg.sv | 17 +
 rtl/ram_byte_array.sv | 40 ++++
 rtl/data_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_data_ram_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and defaults for the data RAM controller and its storage array.
package data_ram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Plain storage: per-byte write enables, registered read, no reset on contents.
module ram_byte_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [be_w(DATA_W)-1:0]   be_i,
    input  logic [IDX_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      re_i,
    input  logic [IDX_W-1:0]          raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    localparam int unsigned BE_W = be_w(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read samples the pre-write contents; the controller forwards colliding bytes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Simple dual-port data RAM controller: clear engine, range check, write-first
// forwarding on same-address collisions and held read data with a valid strobe.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     ctrl_write,
    input  logic [ADDR_W-1:0]        i_addr_write,
    input  logic [DATA_W-1:0]        i_data_write,
    input  logic [be_w(DATA_W)-1:0]  i_byte_en,
    input  logic                     ctrl_read,
    input  logic [ADDR_W-1:0]        i_addr_read,
    output logic [DATA_W-1:0]        o_data_read,
    output logic                     o_read_valid,
    input  logic                     i_clear,
    output logic                     o_busy,
    output logic                     o_addr_err
);

    localparam int unsigned BE_W     = be_w(DATA_W);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, valid_q, oor_q, addr_err_q;
    logic [BE_W-1:0]   fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q, last_q;

    logic              clearing, accept, wr_in_range, rd_in_range;
    logic              wr_ok, rd_ok, wr_oor, rd_oor;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, merged, rd_word;

    assign clearing    = (state_q == ST_CLEAR);
    // The cycle that starts a clear drops any request alongside it.
    assign accept      = (state_q == ST_IDLE) && !i_clear;
    assign wr_in_range = ({1'b0, i_addr_write} < DEPTH_X);
    assign rd_in_range = ({1'b0, i_addr_read} < DEPTH_X);
    assign wr_ok       = accept && ctrl_write && wr_in_range;
    assign rd_ok       = accept && ctrl_read && rd_in_range;
    assign wr_oor      = accept && ctrl_write && !wr_in_range;
    assign rd_oor      = accept && ctrl_read && !rd_in_range;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == CLR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign mem_we    = clearing || wr_ok;
    assign mem_be    = clearing ? '1 : i_byte_en;
    assign mem_waddr = IDX_W'(clearing ? clr_ptr_q : i_addr_write);
    assign mem_wdata = clearing ? '0 : i_data_write;

    ram_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (i_clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (rd_ok),
        .raddr_i (IDX_W'(i_addr_read)),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        merged = mem_rdata;
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_be_q[b]) begin
                merged[8*b +: 8] = fwd_data_q[8*b +: 8];
            end
        end
        rd_word = oor_q ? '0 : merged;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            oor_q      <= 1'b0;
            addr_err_q <= 1'b0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            busy_q     <= (state_d == ST_CLEAR);
            valid_q    <= rd_ok || rd_oor;
            oor_q      <= rd_oor;
            addr_err_q <= wr_oor || rd_oor;
            fwd_be_q   <= (wr_ok && rd_ok && (i_addr_write == i_addr_read)) ? i_byte_en : '0;
            fwd_data_q <= i_data_write;
            if (valid_q) begin
                last_q <= rd_word;
            end
        end
    end

    assign o_data_read  = valid_q ? rd_word : last_q;
    assign o_read_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_addr_err   = addr_err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl (16x16, 8-bit address) with a shadow model and
// a per-cycle scoreboard of expected read/valid/error outputs.
module tb_data_ram_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int DEP = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          ctrl_write, ctrl_read, i_clear;
    logic [AW-1:0] i_addr_write, i_addr_read;
    logic [DW-1:0] i_data_write, o_data_read;
    logic [1:0]    i_byte_en;
    logic          o_read_valid, o_busy, o_addr_err;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model [DEP];
    logic [DW-1:0] last_out = '0;
    logic [DW+1:0] exp_q [$];
    string         tag_q [$];

    data_ram_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .ctrl_write   (ctrl_write),
        .i_addr_write (i_addr_write),
        .i_data_write (i_data_write),
        .i_byte_en    (i_byte_en),
        .ctrl_read    (ctrl_read),
        .i_addr_read  (i_addr_read),
        .o_data_read  (o_data_read),
        .o_read_valid (o_read_valid),
        .i_clear      (i_clear),
        .o_busy       (o_busy),
        .o_addr_err   (o_addr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model applies the write before the read, giving write-first collision data.
    task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                         input logic [1:0] be, input logic re, input int ra,
                         input logic clr, input string tag);
        ctrl_write   = we;
        i_addr_write = AW'(wa);
        i_data_write = wd;
        i_byte_en    = be;
        ctrl_read    = re;
        i_addr_read  = AW'(ra);
        i_clear      = clr;
        if (!clr) begin
            if (we && wa < DEP) begin
                for (int b = 0; b < 2; b++) begin
                    if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
                end
            end
            if (re) last_out = (ra < DEP) ? model[ra] : '0;
        end
        exp_q.push_back({re && !clr, !clr && ((we && wa >= DEP) || (re && ra >= DEP)),
                         last_out});
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        logic [DW+1:0] e;
        string         t;
        @(posedge i_clk);
        #1;
        ctrl_write = 1'b0;
        ctrl_read  = 1'b0;
        i_clear    = 1'b0;
        i_byte_en  = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".valid"}, 32'(o_read_valid), 32'(e[DW+1]));
            check({t, ".err"}, 32'(o_addr_err), 32'(e[DW]));
            check({t, ".data"}, 32'(o_data_read), 32'(e[DW-1:0]));
        end
    endtask

    // Counts busy cycles from now; optionally pulses i_clear once mid-sweep.
    task automatic count_busy(input string tag, input int clr_at);
        int n = 0;
        while (o_busy && n < 100) begin
            i_clear = (n == clr_at);
            n++;
            @(posedge i_clk);
            #1;
        end
        i_clear = 1'b0;
        check(tag, 32'(n), 32'(DEP));
        for (int i = 0; i < DEP; i++) model[i] = '0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEP; a++) begin
            drive(1'b0, 0, '0, 2'b00, 1'b1, a, 1'b0, tag);
            tick();
        end
    endtask

    initial begin
        i_rst = 1'b1;
        ctrl_write = 1'b0; ctrl_read = 1'b0; i_clear = 1'b0;
        i_addr_write = '0; i_addr_read = '0; i_data_write = '0; i_byte_en = '0;
        repeat (3) tick();
        check("rst.busy", 32'(o_busy), 32'd1);
        check("rst.valid", 32'(o_read_valid), 32'd0);
        check("rst.data", 32'(o_data_read), 32'd0);
        check("rst.err", 32'(o_addr_err), 32'd0);
        i_rst = 1'b0;
        count_busy("t1_sweep_len", -1);
        read_all("t1_read");

        drive(1'b1, 3, 16'hBEEF, 2'b11, 1'b0, 0, 1'b0, "t2_w_full");
        tick();
        drive(1'b1, 3, 16'h1234, 2'b01, 1'b0, 0, 1'b0, "t2_w_low");
        tick();
        drive(1'b0, 0, '0, 2'b00, 1'b1, 3, 1'b0, "t2_read");
        tick();
        check("t2_const", 32'(o_data_read), 32'h0000BE34);

        drive(1'b1, 5, 16'h0011, 2'b11, 1'b0, 0, 1'b0, "t3_seed");
        tick();
        drive(1'b1, 5, 16'hAAAA, 2'b10, 1'b1, 5, 1'b0, "t3_collide");
        tick();
        check("t3_const", 32'(o_data_read), 32'h0000AA11);
        drive(1'b1, 6, 16'h7777, 2'b11, 1'b1, 5, 1'b0, "t3_diff_addr");
        tick();

        drive(1'b1, 20, 16'h5555, 2'b11, 1'b0, 0, 1'b0, "t4_oor_w");
        tick();
        drive(1'b0, 0, '0, 2'b00, 1'b1, 20, 1'b0, "t4_oor_r");
        tick();
        tick();
        check("t4_err_clear", 32'(o_addr_err), 32'd0);
        check("t4_valid_clear", 32'(o_read_valid), 32'd0);
        read_all("t4_sweep");

        for (int a = 0; a < DEP; a++) begin
            drive(1'b1, a, 16'hFFFF, 2'b11, 1'b0, 0, 1'b0, "t5_fill");
            tick();
        end
        drive(1'b1, 2, 16'h1234, 2'b11, 1'b0, 0, 1'b1, "t5_clear");
        tick();
        count_busy("t5_sweep_len", 5);
        read_all("t5_read");

        drive(1'b1, 1, 16'hBEEF, 2'b11, 1'b0, 0, 1'b0, "t6_seed");
        tick();
        drive(1'b0, 0, '0, 2'b00, 1'b1, 1, 1'b0, "t6_pre_read");
        tick();
        drive(1'b0, 0, '0, 2'b00, 1'b0, 0, 1'b1, "t6_clear");
        tick();
        repeat (7) tick();
        i_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_rst.busy", 32'(o_busy), 32'd1);
            check("t6_rst.valid", 32'(o_read_valid), 32'd0);
            check("t6_rst.data", 32'(o_data_read), 32'd0);
        end
        i_rst = 1'b0;
        last_out = '0;
        count_busy("t6_sweep_len", -1);
        read_all("t6_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
